// File: rtl/adder_pkg.sv
// ============================================================================
// Module  : adder_pkg
// Brief   : Shared types and helpers for the digit-serial adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } dsa_state_t;

    // Guarded so a bad DIGIT reaches the elaboration check instead of a divide-by-zero.
    function automatic int num_digits(input int width, input int digit);
        return (digit > 0) ? (width / digit) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_serial_adder_if.sv
// ============================================================================
// Module  : digit_serial_adder_if
// Brief   : Request/response handshake bundle for the digit-serial adder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

`default_nettype wire

// File: rtl/digit_slice.sv
// ============================================================================
// Module  : digit_slice
// Brief   : Combinational DIGIT-bit ripple adder built from full-adder cells.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digit_slice #(
    parameter int DIGIT = 2
) (
    input  wire logic [DIGIT-1:0] x,
    input  wire logic [DIGIT-1:0] y,
    input  wire logic             ci,
    output logic      [DIGIT-1:0] s,
    output logic                  co
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_bit
            full_adder u_fa (
                .i_a (x[i]),
                .i_b (y[i]),
                .i_c (w_c[i]),
                .o_s (s[i]),
                .o_c (w_c[i+1])
            );
        end
    endgenerate

    assign co = w_c[DIGIT];
endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module  : full_adder
// Brief   : Single-bit full-adder cell.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module full_adder (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_c,
    output logic      o_s,
    output logic      o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

`default_nettype wire

// File: rtl/digit_serial_adder.sv
// ============================================================================
// Module  : digit_serial_adder
// Brief   : Handshaked adder computing WIDTH-bit sums DIGIT bits per clock.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = num_digits(WIDTH, DIGIT);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    dsa_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_s_ext;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;

    digit_slice #(.DIGIT(DIGIT)) u_slice (
        .x  (r_a[DIGIT-1:0]),
        .y  (r_b[DIGIT-1:0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New digit enters at the top; after NDIG shifts the first digit lands at bit 0.
    assign w_s_ext    = WIDTH'(w_s);
    assign w_sum_next = (r_sum >> DIGIT) | (w_s_ext << (WIDTH - DIGIT));
    assign w_last     = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_sum   <= w_sum_next;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_co;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_digit_serial_adder.sv
// ============================================================================
// Module  : tb_digit_serial_adder
// Brief   : Self-checking bench for digit_serial_adder (table + scoreboard).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_digit_serial_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(8))  dif   ();
    digit_serial_adder_if #(.WIDTH(8))  if81  ();
    digit_serial_adder_if #(.WIDTH(8))  if88  ();
    digit_serial_adder_if #(.WIDTH(12)) if123 ();

    digit_serial_adder #(.WIDTH(8),  .DIGIT(2)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(dif.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) u_dut81 (.clk(clk), .rst_n(rst_n), .bus(if81.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) u_dut88 (.clk(clk), .rst_n(rst_n), .bus(if88.slave));
    digit_serial_adder #(.WIDTH(12), .DIGIT(3)) u_dut123(.clk(clk), .rst_n(rst_n), .bus(if123.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t       vt [8];
    logic [8:0] sb_q [$];
    int         checks = 0;
    int         errors = 0;
    int         n_push = 0;
    int         n_pop  = 0;
    bit         done   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Accepts are seen mid-cycle, where the handshake for the next edge is settled.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dif.in_valid && dif.in_ready) begin
                    sb_q.push_back({1'b0, dif.a} + {1'b0, dif.b} + {8'd0, dif.cin});
                    n_push++;
                end
                if (dif.out_valid && dif.out_ready) begin
                    if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                    else chk("sb_result", {23'd0, dif.cout, dif.sum}, {23'd0, sb_q.pop_front()});
                    n_pop++;
                end
            end
        end
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output int lat, output logic [7:0] s, output logic co);
        int g;
        @(posedge clk); #1;
        dif.a = a; dif.b = b; dif.cin = cin; dif.in_valid = 1'b1;
        g = 0;
        while (!dif.in_ready && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        lat = 0;
        while (!dif.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        s  = dif.sum;
        co = dif.cout;
        @(posedge clk); #1;
    endtask

    initial begin
        int         lat, l81, l88, l123, g, push0, pop0;
        logic [7:0] s, s81, s88, s0;
        logic [11:0] s123;
        logic       co, c81, c88, c123, c0;

        vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[1] = '{8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vt[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vt[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        dif.in_valid = 0; dif.a = 0; dif.b = 0; dif.cin = 0; dif.out_ready = 1;
        if81.in_valid = 0; if81.a = 0; if81.b = 0; if81.cin = 0; if81.out_ready = 1;
        if88.in_valid = 0; if88.a = 0; if88.b = 0; if88.cin = 0; if88.out_ready = 1;
        if123.in_valid = 0; if123.a = 0; if123.b = 0; if123.cin = 0; if123.out_ready = 1;

        fork monitor(); join_none

        #3;
        chk("rst_in_ready",  {31'd0, dif.in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, dif.busy},      32'd0);
        chk("rst_sum",       {24'd0, dif.sum},       32'd0);
        chk("rst_cout",      {31'd0, dif.cout},      32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Degenerate and odd configurations run side by side.
        @(posedge clk); #1;
        if81.a = 8'hC5;  if81.b = 8'h4E;  if81.cin = 1'b1;  if81.in_valid = 1'b1;
        if88.a = 8'hC5;  if88.b = 8'h4E;  if88.cin = 1'b1;  if88.in_valid = 1'b1;
        if123.a = 12'hABC; if123.b = 12'h987; if123.cin = 1'b1; if123.in_valid = 1'b1;
        @(posedge clk); #1;
        if81.in_valid = 1'b0; if88.in_valid = 1'b0; if123.in_valid = 1'b0;
        l81 = -1; l88 = -1; l123 = -1;
        s81 = 0; s88 = 0; s123 = 0; c81 = 0; c88 = 0; c123 = 0;
        for (int k = 0; k <= 12; k++) begin
            if (l81 < 0 && if81.out_valid)   begin l81 = k;  s81 = if81.sum;   c81 = if81.cout;   end
            if (l88 < 0 && if88.out_valid)   begin l88 = k;  s88 = if88.sum;   c88 = if88.cout;   end
            if (l123 < 0 && if123.out_valid) begin l123 = k; s123 = if123.sum; c123 = if123.cout; end
            @(posedge clk); #1;
        end
        chk("cfg8_1_lat",  l81,  32'd8);
        chk("cfg8_1_res",  {23'd0, c81, s81},   32'h114);
        chk("cfg8_8_lat",  l88,  32'd1);
        chk("cfg8_8_res",  {23'd0, c88, s88},   32'h114);
        chk("cfg12_3_lat", l123, 32'd4);
        chk("cfg12_3_res", {19'd0, c123, s123}, 32'h1444);

        for (int i = 0; i < 8; i++) begin
            do_txn(vt[i].a, vt[i].b, vt[i].cin, lat, s, co);
            chk("vec_latency", lat, 32'd4);
            chk("vec_sum",     {24'd0, s},  {24'd0, vt[i].s});
            chk("vec_cout",    {31'd0, co}, {31'd0, vt[i].co});
            chk("vec_in_ready_after", {31'd0, dif.in_ready}, 32'd1);
        end

        // Backpressure in DONE with a new request held pending.
        dif.out_ready = 1'b0;
        @(posedge clk); #1;
        dif.a = 8'h9E; dif.b = 8'h77; dif.cin = 1'b1; dif.in_valid = 1'b1;
        @(posedge clk); #1;
        dif.a = 8'h21; dif.b = 8'h43; dif.cin = 1'b0;
        g = 0;
        while (!dif.out_valid && g < 50) begin @(posedge clk); #1; g++; end
        s0 = dif.sum; c0 = dif.cout;
        chk("bp_first_result", {23'd0, c0, s0}, 32'h116);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, dif.out_valid}, 32'd1);
            chk("bp_sum_hold",  {23'd0, dif.cout, dif.sum}, {23'd0, c0, s0});
            chk("bp_in_ready",  {31'd0, dif.in_ready}, 32'd0);
        end
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("bp_released_in_ready",  {31'd0, dif.in_ready},  32'd1);
        @(posedge clk); #1;
        chk("bp_held_accepted", {31'd0, dif.busy}, 32'd1);
        dif.in_valid = 1'b0;
        g = 0;
        while (!dif.out_valid && g < 50) begin @(posedge clk); #1; g++; end
        chk("bp_second_result", {23'd0, dif.cout, dif.sum}, 32'h064);
        @(posedge clk); #1;

        // Reset pulse during the second CALC cycle.
        dif.a = 8'h55; dif.b = 8'h66; dif.cin = 1'b0; dif.in_valid = 1'b1;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  {31'd0, dif.in_ready},  32'd1);
        chk("arst_out_valid", {31'd0, dif.out_valid}, 32'd0);
        chk("arst_busy",      {31'd0, dif.busy},      32'd0);
        chk("arst_sum",       {24'd0, dif.sum},       32'd0);
        chk("arst_cout",      {31'd0, dif.cout},      32'd0);
        sb_q.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        do_txn(8'h10, 8'h20, 1'b0, lat, s, co);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_res", {23'd0, co, s}, 32'h030);

        // Back-to-back random traffic with random consumer stalls.
        push0 = n_push; pop0 = n_pop;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    dif.a = 8'($urandom); dif.b = 8'($urandom);
                    dif.cin = 1'($urandom); dif.in_valid = 1'b1;
                    g = 0;
                    @(negedge clk);
                    while (!dif.in_ready && g < 100) begin @(negedge clk); g++; end
                    if (g >= 100) begin
                        chk("rand_accept_timeout", 32'd1, 32'd0);
                        break;
                    end
                    @(posedge clk); #1;
                end
                dif.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    dif.out_ready = ($urandom_range(0, 3) != 0);
                end
                dif.out_ready = 1'b1;
            end
        join
        g = 0;
        while ((sb_q.size() != 0 || dif.busy) && g < 100) begin @(posedge clk); #1; g++; end
        #6;
        chk("rand_pushes", n_push - push0, 32'd1000);
        chk("rand_pops",   n_pop - pop0,   32'd1000);
        chk("rand_queue_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Sequential responder for the team's adder interface: it accepts an operand pair (a, b, cin) on a valid/ready request channel and returns (sum, cout) on a valid/ready response channel.
- It computes the WIDTH-bit sum DIGIT bits per clock, least-significant digit first, carrying between digits through a carry register.
- It is the clocked, handshaked counterpart to the combinational TFA_xbit adders and drops into the same adder_interface-based test environment.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- DIGIT, 2, bits added per CALC cycle; must be at least 1 and divide WIDTH evenly (elaboration-time assertion).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request carries valid operands.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A, sampled on the accept edge.
- b  input  WIDTH  operand B, sampled on the accept edge.
- cin  input  1  carry in, sampled on the accept edge.
- out_valid  output  1  response is valid.
- out_ready  input  1  consumer takes the response.
- sum  output  WIDTH  result, (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in CALC or DONE.

Behaviour:
- NDIG = WIDTH/DIGIT.
- State machine states: IDLE, CALC, DONE.
- Reset (rst_n low, asynchronous): state=IDLE, digit counter=0, carry register=0, operand and result registers=0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Requests are ignored while rst_n is low.
- in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE. All three are decoded from state only, with no combinational path from in_valid or out_ready.
- IDLE:
  - On an edge with in_valid=1, capture a, b and cin; load cin into the carry register; clear the counter; go to CALC.
  - With in_valid=0, stay in IDLE.
- CALC, each cycle:
  - The digit_slice adds the low DIGIT bits of the A and B shift registers plus the carry register.
  - The DIGIT-bit result is shifted into the top of the sum register, whose contents move right by DIGIT. The operand registers also shift right by DIGIT.
  - The carry register takes the slice carry-out. The counter increments.
  - On the cycle with counter==NDIG-1, go to DONE and load cout from the slice carry-out.
- DONE:
  - sum and cout are held stable and out_valid=1 until an edge with out_ready=1, then go to IDLE.
  - out_ready is ignored in all other states.
- Latency: request accepted at edge t; out_valid rises after edge t+NDIG. A response accepted at edge u gives in_ready=1 after edge u.
  - Best-case throughput is one transaction per NDIG+2 cycles.
- sum and cout show intermediate values during CALC. Consumers must qualify them with out_valid. Registers are not cleared between transactions.
- Boundaries:
  - a=b=all-ones with cin=1 gives sum=all-ones, cout=1.
  - Wrap-around is modulo 2^WIDTH with no saturation.
  - in_valid held high while busy is not accepted and is not lost; the source holds it per the handshake.
  - Reset asserted mid-CALC or mid-DONE aborts the transaction immediately. No response is produced.
  - Degenerate configurations:
    - DIGIT=WIDTH: NDIG=1, one CALC cycle.
    - DIGIT=1: bit-serial, WIDTH CALC cycles.
- Counter width: $clog2(NDIG) bits, minimum 1.

Decomposition:
- Shared package adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} dsa_state_t.
  - A function num_digits(width, digit) returning WIDTH/DIGIT.
- One sub-module, digit_slice #(DIGIT): combinational DIGIT-bit ripple adder.
  - Inputs: x, y, ci. Outputs: s, co.
  - Built from the existing full-adder cell.
  - Verified standalone by exhaustive sweep for DIGIT up to 4.

Test Plan (WIDTH=8, DIGIT=2, unless stated):
- a=0xFF, b=0x01, cin=0, out_ready=1 -> out_valid rises exactly 4 cycles after the accept edge; sum=0x00, cout=1; in_ready returns 1 the cycle after the response is taken.
- a=0x3C, b=0x5A, cin=1 -> sum=0x97, cout=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> sum, cout and out_valid stay stable; in_ready=0 throughout; a held in_valid is accepted only after the response handshake.
- Reset pulse (rst_n low for 1 cycle) during the 2nd CALC cycle -> outputs return to 0 and in_ready=1 asynchronously; a new request a=0x10, b=0x20, cin=0 then yields 0x30 with cout=0.
- 1000 back-to-back random requests with random out_ready stalls -> scoreboard matches {cout,sum}=a+b+cin and no transaction is dropped or duplicated.
- Configurations WIDTH=8/DIGIT=1 (latency 8), WIDTH=8/DIGIT=8 (latency 1) and WIDTH=12/DIGIT=3 (latency 4) -> correct results and latencies; WIDTH=8, DIGIT=3 -> elaboration error.
